// File: rtl/spirose_pkg.sv
// Shared constants and types for the slice ping-pong RAM FIFO path.
package spirose_pkg;

  localparam int SLICE_WORDS = 256;
  localparam int N_SLICES    = 128;
  localparam int PIX_W       = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef enum logic {FILL, COMMIT} slice_wr_state_t;

endpackage

// File: rtl/slice_writer.sv
// Packs a valid/ready pixel stream into SLICE_WORDS-word slices and drives the slice FIFO write port.
// Writes appear one cycle after acceptance; the stream stalls one cycle per slice and while the FIFO is full.
module slice_writer #(
  parameter int SLICE_WORDS = spirose_pkg::SLICE_WORDS,
  parameter int N_SLICES    = spirose_pkg::N_SLICES,
  parameter int DATA_W      = spirose_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  output logic              pix_ready,
  input  logic              fifo_full,
  output logic [7:0]        waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wenable,
  output logic [7:0]        wslice_number,
  output logic              EOS,
  output logic              sync_err,
  output logic              frame_done
);

  import spirose_pkg::*;

  localparam logic [7:0] LAST_ADDR  = 8'(SLICE_WORDS - 1);
  localparam logic [7:0] LAST_SLICE = 8'(N_SLICES - 1);

  slice_wr_state_t   state_q, state_d;
  logic [7:0]        addr_cnt_q, addr_cnt_d;
  logic [7:0]        slice_cnt_q, slice_cnt_d;
  logic [7:0]        waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wenable_q, wenable_d;
  logic              sync_err_q, sync_err_d;
  logic [7:0]        eff_addr;
  logic              eos_c;
  logic              frame_done_c;
  logic              ready_c;

  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    slice_cnt_d  = slice_cnt_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wenable_d    = 1'b0;
    sync_err_d   = 1'b0;
    eff_addr     = addr_cnt_q;
    eos_c        = 1'b0;
    frame_done_c = 1'b0;
    ready_c      = 1'b0;

    case (state_q)
      FILL: begin
        ready_c = 1'b1;
        if (pix_valid) begin
          // SOF snaps both counters to the frame origin before the normal increment.
          if (pix_sof) begin
            eff_addr    = 8'd0;
            slice_cnt_d = 8'd0;
            sync_err_d  = (addr_cnt_q != 8'd0) || (slice_cnt_q != 8'd0);
          end
          waddr_d   = eff_addr;
          wdata_d   = pix_data;
          wenable_d = 1'b1;
          if (eff_addr == LAST_ADDR) begin
            addr_cnt_d = 8'd0;
            state_d    = COMMIT;
          end else begin
            addr_cnt_d = eff_addr + 8'd1;
          end
        end
      end
      COMMIT: begin
        eos_c = ~fifo_full;
        if (!fifo_full) begin
          frame_done_c = (slice_cnt_q == LAST_SLICE);
          slice_cnt_d  = frame_done_c ? 8'd0 : slice_cnt_q + 8'd1;
          state_d      = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      addr_cnt_q  <= 8'd0;
      slice_cnt_q <= 8'd0;
      waddr_q     <= 8'd0;
      wdata_q     <= '0;
      wenable_q   <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_cnt_q  <= addr_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      wenable_q   <= wenable_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign pix_ready     = ready_c;
  assign waddr         = waddr_q;
  assign wdata         = wdata_q;
  assign wenable       = wenable_q;
  assign wslice_number = slice_cnt_q;
  assign EOS           = eos_c;
  assign sync_err      = sync_err_q;
  assign frame_done    = frame_done_c;

endmodule

// File: tb/tb_slice_writer.sv
// Directed bench for slice_writer with a slice FIFO model capturing committed slices.
module tb_slice_writer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [23:0] pix_data = '0;
  logic        man_full = 1'b0;
  logic        rnd_full = 1'b0;
  logic        rnd_mode = 1'b0;
  wire         fifo_full = rnd_mode ? rnd_full : man_full;

  logic        pix_ready, wenable, eos, sync_err, frame_done;
  logic [7:0]  waddr, wslice_number;
  logic [23:0] wdata;

  slice_writer #(.SLICE_WORDS(256), .N_SLICES(128), .DATA_W(24)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .fifo_full(fifo_full), .waddr(waddr), .wdata(wdata),
    .wenable(wenable), .wslice_number(wslice_number), .EOS(eos), .sync_err(sync_err),
    .frame_done(frame_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slice FIFO model: write lands before commit on the same edge.
  logic [23:0] wbuf [256];
  logic [23:0] cq [$];
  int          eos_sl [$];
  int          fd_cnt = 0, fd_bad = 0, se_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      cq.delete();
      eos_sl.delete();
      fd_cnt <= 0;
      fd_bad <= 0;
      se_cnt <= 0;
    end else begin
      if (wenable) wbuf[waddr] <= wdata;
      if (eos) begin
        for (int j = 0; j < 256; j++)
          cq.push_back((wenable && waddr == 8'(j)) ? wdata : wbuf[j]);
        eos_sl.push_back(int'(wslice_number));
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        if (!eos || wslice_number != 8'd127) fd_bad <= fd_bad + 1;
      end
      if (sync_err) se_cnt <= se_cnt + 1;
    end
  end

  always @(negedge clk) rnd_full <= ($urandom_range(0, 2) == 0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [23:0] d, input logic sof);
    logic acc;
    int   t;
    t = 0;
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    do begin
      acc = pix_ready;
      step();
      t++;
    end while (!acc && t < 1000);
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_pix_ready"}, 32'(pix_ready), 32'd1);
    chk({p, "_wenable"}, 32'(wenable), 32'd0);
    chk({p, "_waddr"}, 32'(waddr), 32'd0);
    chk({p, "_wdata"}, 32'(wdata), 32'd0);
    chk({p, "_wslice"}, 32'(wslice_number), 32'd0);
    chk({p, "_eos"}, 32'(eos), 32'd0);
    chk({p, "_sync_err"}, 32'(sync_err), 32'd0);
    chk({p, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;

    // Reset state
    idle(2);
    chk_reset("rst");
    rst = 1'b0;

    // One slice of consecutive beats, data = i
    for (int i = 0; i < 256; i++) begin
      send(24'(i), 1'b0);
      chk("t1_waddr", 32'(waddr), i);
      chk("t1_wdata", 32'(wdata), i);
    end
    chk("t1_wen_last", 32'(wenable), 32'd1);
    chk("t1_eos", 32'(eos), 32'd1);
    chk("t1_eos_slice", 32'(wslice_number), 32'd0);
    chk("t1_commit_ready", 32'(pix_ready), 32'd0);
    idle(1);
    chk("t1_eos_drop", 32'(eos), 32'd0);
    chk("t1_slice_next", 32'(wslice_number), 32'd1);
    chk("t1_wen_drop", 32'(wenable), 32'd0);
    chk("t1_ready_back", 32'(pix_ready), 32'd1);
    chk("t1_eos_count", eos_sl.size(), 32'd1);
    bad = 0;
    for (int i = 0; i < 256; i++) if (cq[i] !== 24'(i)) bad++;
    chk("t1_sb", bad, 32'd0);

    // FIFO full held for 10 cycles at COMMIT
    man_full = 1'b1;
    for (int i = 0; i < 256; i++) send(24'(1000 + i), 1'b0);
    for (int c = 0; c < 10; c++) begin
      chk("t2_stall_ready", 32'(pix_ready), 32'd0);
      chk("t2_stall_eos", 32'(eos), 32'd0);
      step();
    end
    man_full = 1'b0;
    #1;
    chk("t2_eos_release", 32'(eos), 32'd1);
    chk("t2_eos_slice", 32'(wslice_number), 32'd1);
    idle(1);
    chk("t2_slice_next", 32'(wslice_number), 32'd2);
    chk("t2_eos_count", eos_sl.size(), 32'd2);
    bad = 0;
    for (int i = 0; i < 256; i++) if (cq[256 + i] !== 24'(1000 + i)) bad++;
    chk("t2_sb", bad, 32'd0);

    // Full frame of 128 slices
    do_reset();
    for (int s = 0; s < 128; s++)
      for (int a = 0; a < 256; a++) send(24'(s * 256 + a), (s == 0 && a == 0));
    chk("t3_frame_done", 32'(frame_done), 32'd1);
    chk("t3_last_eos", 32'(eos), 32'd1);
    chk("t3_last_slice", 32'(wslice_number), 32'd127);
    idle(1);
    chk("t3_slice_wrap", 32'(wslice_number), 32'd0);
    chk("t3_fd_drop", 32'(frame_done), 32'd0);
    chk("t3_eos_count", eos_sl.size(), 32'd128);
    bad = 0;
    for (int s = 0; s < eos_sl.size(); s++) if (eos_sl[s] != s) bad++;
    chk("t3_slice_order", bad, 32'd0);
    chk("t3_fd_count", fd_cnt, 32'd1);
    chk("t3_fd_align", fd_bad, 32'd0);
    chk("t3_no_sync_err", se_cnt, 32'd0);
    bad = 0;
    for (int k = 0; k < cq.size(); k++) if (cq[k] !== 24'(k)) bad++;
    chk("t3_sb", bad, 32'd0);

    // SOF arriving on beat 100 of slice 3
    do_reset();
    for (int k = 0; k < 3 * 256 + 100; k++) send(24'(k), 1'b0);
    chk("t4_pre_slice", 32'(wslice_number), 32'd3);
    send(24'hABCDEF, 1'b1);
    chk("t4_sync_err", 32'(sync_err), 32'd1);
    chk("t4_sof_waddr", 32'(waddr), 32'd0);
    chk("t4_sof_slice", 32'(wslice_number), 32'd0);
    chk("t4_sof_wdata", 32'(wdata), 32'hABCDEF);
    idle(1);
    chk("t4_sync_err_drop", 32'(sync_err), 32'd0);
    for (int i = 0; i < 255; i++) send(24'h500000 + 24'(i), 1'b0);
    chk("t4_eos", 32'(eos), 32'd1);
    chk("t4_eos_slice", 32'(wslice_number), 32'd0);
    idle(1);
    chk("t4_eos_count", eos_sl.size(), 32'd4);
    bad = 0;
    for (int s = 0; s < eos_sl.size(); s++) if (eos_sl[s] == 3) bad++;
    chk("t4_no_slice3", bad, 32'd0);
    chk("t4_se_count", se_cnt, 32'd1);
    bad = 0;
    if (cq[768] !== 24'hABCDEF) bad++;
    for (int i = 0; i < 255; i++) if (cq[769 + i] !== 24'h500000 + 24'(i)) bad++;
    chk("t4_sb", bad, 32'd0);

    // Random valid gaps and random FIFO full
    do_reset();
    rnd_mode = 1'b1;
    for (int k = 0; k < 3 * 256; k++) begin
      idle($urandom_range(0, 2));
      send(24'h300000 + 24'(k), 1'b0);
    end
    rnd_mode = 1'b0;
    idle(3);
    chk("t5_eos_count", eos_sl.size(), 32'd3);
    bad = 0;
    for (int s = 0; s < eos_sl.size(); s++) if (eos_sl[s] != s) bad++;
    chk("t5_slice_order", bad, 32'd0);
    chk("t5_sb_size", cq.size(), 32'd768);
    bad = 0;
    for (int k = 0; k < cq.size(); k++) if (cq[k] !== 24'h300000 + 24'(k)) bad++;
    chk("t5_sb", bad, 32'd0);

    // Reset at address 50 of slice 5
    do_reset();
    for (int k = 0; k < 5 * 256 + 50; k++) send(24'h600000 + 24'(k), 1'b0);
    chk("t6_pre_slice", 32'(wslice_number), 32'd5);
    chk("t6_pre_waddr", 32'(waddr), 32'd49);
    rst = 1'b1;
    idle(1);
    chk_reset("t6_rst");
    rst = 1'b0;
    send(24'h777777, 1'b0);
    chk("t6_waddr", 32'(waddr), 32'd0);
    chk("t6_slice", 32'(wslice_number), 32'd0);
    chk("t6_wen", 32'(wenable), 32'd1);
    chk("t6_wdata", 32'(wdata), 32'h777777);
    chk("t6_no_eos", eos_sl.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
